// File: rtl/instr_memory_loader.sv
// Instruction memory loader: assembles big-endian 16-bit words from a byte
// stream and drives the instruction memory write port, one word per strobe.
module instr_memory_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   num_words,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam logic [ADDR_WIDTH:0] MAX_WORDS = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE_WORD  = (ADDR_WIDTH+1)'(1);

  typedef enum logic [2:0] {
    IDLE,
    RECV_HI,
    RECV_LO,
    WRITE,
    DONE
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH:0]   remain;
  logic [7:0]            hi_byte;
  logic                  take;

  // A load must write at least one word and cannot exceed the memory.
  function automatic logic count_ok(input logic [ADDR_WIDTH:0] n);
    return (n != '0) && (n <= MAX_WORDS);
  endfunction

  assign take = byte_valid && byte_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      addr        <= '0;
      remain      <= '0;
      hi_byte     <= '0;
      byte_ready  <= 1'b0;
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      mem_wr_en <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (count_ok(num_words)) begin
              addr       <= base_addr;
              remain     <= num_words;
              byte_ready <= 1'b1;
              busy       <= 1'b1;
              state      <= RECV_HI;
            end else begin
              error <= 1'b1;
            end
          end
        end
        RECV_HI: begin
          if (take) begin
            hi_byte <= byte_in;
            state   <= RECV_LO;
          end
        end
        RECV_LO: begin
          if (take) begin
            mem_wr_en   <= 1'b1;
            mem_wr_addr <= addr;
            mem_wr_data <= {hi_byte, byte_in};
            byte_ready  <= 1'b0;
            state       <= WRITE;
          end
        end
        WRITE: begin
          // Address wraps naturally because DEPTH is a power of two.
          addr   <= addr + 1'b1;
          remain <= remain - 1'b1;
          if (remain == ONE_WORD) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end else begin
            byte_ready <= 1'b1;
            state      <= RECV_HI;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          byte_ready <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/instr_memory_loader.md
Name: instr_memory_loader

Overview:
Write-side companion to the miniMIPS instruction memory block. It accepts a byte stream from a host or boot source over a valid/ready handshake and assembles big-endian 16-bit instruction words. It drives the instruction memory write port with one word per write strobe, starting at a programmable base address. Typical use is filling the 64-entry instruction memory before the CPU starts fetching.

Parameters:
DATA_WIDTH, 16, instruction word width; must be 2x byte width.
ADDR_WIDTH, 6, instruction memory address width.
DEPTH, 64, number of memory words; equals 2**ADDR_WIDTH.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  request a load; sampled only in IDLE.
base_addr  input  ADDR_WIDTH  first write address; captured on an accepted start.
num_words  input  ADDR_WIDTH+1  words to load; legal range 1..DEPTH; captured on an accepted start.
byte_in  input  8  stream byte.
byte_valid  input  1  byte_in is valid.
byte_ready  output  1  loader accepts a byte this cycle.
mem_wr_en  output  1  instruction memory write strobe, one cycle per word.
mem_wr_addr  output  ADDR_WIDTH  write address.
mem_wr_data  output  DATA_WIDTH  write data, {high byte, low byte}.
busy  output  1  load in progress.
done  output  1  one-cycle pulse after the last word is written.
error  output  1  one-cycle pulse when start is rejected.

Behaviour:
- Reset (asynchronous, any state): state is IDLE. All outputs are 0, including mem_wr_addr, mem_wr_data, the internal address, the remaining-word count and the high-byte register. No write occurs in the reset cycle or in the first cycle after reset is released.
- All outputs are registered. byte_ready is a decode of the current state.
- IDLE:
  - byte_ready=0, busy=0.
  - start with num_words 1..DEPTH: capture addr=base_addr and remain=num_words, then go to RECV_HI. busy=1 from the next cycle.
  - start with num_words=0 or >DEPTH: pulse error=1 for one cycle and stay in IDLE.
- RECV_HI:
  - byte_ready=1.
  - On byte_valid&&byte_ready: latch hi=byte_in and go to RECV_LO.
  - No handshake: hold state, with no timeout.
- RECV_LO:
  - byte_ready=1.
  - On handshake: next cycle mem_wr_en=1, mem_wr_addr=addr, mem_wr_data={hi,byte_in}, and go to WRITE.
- WRITE:
  - The strobe cycle; byte_ready=0.
  - Next edge: mem_wr_en=0, addr=addr+1 modulo DEPTH (63 wraps to 0), remain=remain-1.
  - If remain was 1, go to DONE; otherwise go to RECV_HI.
- Write timing: a word costs at least 3 cycles (hi accept, lo accept, write). Latency from the low-byte handshake edge to mem_wr_en high is 1 cycle.
- DONE: done=1 for exactly one cycle, busy=0 in this cycle, then go to IDLE.
- Held outputs: mem_wr_addr and mem_wr_data hold their last values when mem_wr_en=0.
- start while busy: ignored. No error pulse and no change to the load in progress.
- byte_valid while byte_ready=0: the byte is not consumed. The source must hold it until the handshake.
- Wrap-around: a load that crosses address 63 continues at 0. There is no overlap check; num_words=DEPTH writes every address exactly once.
- Reset mid-load: abort immediately. A partially assembled word is discarded and no write is issued for it. Words already written stay in memory.
- Read interaction: the memory's read port is unaffected. A read of an address in the same cycle as its write returns the pre-write content, following the memory's own timing.

Test Plan:
1. Basic load: reset, start with base_addr=0, num_words=2, then bytes 8'h12, 8'h34, 8'hAB, 8'hCD with byte_valid held high. Expect mem_wr_en pulses writing addr 0 data 16'h1234 and addr 1 data 16'hABCD, one done pulse, busy low afterwards, and a memory read of address 0 returning 16'h1234.
2. Wrap-around: base_addr=6'd62, num_words=4, bytes 01..08. Expect writes to 62=0x0102, 63=0x0304, 0=0x0506, 1=0x0708, then done.
3. Illegal start: num_words=0, then num_words=65. Expect an error pulse each time, no byte_ready, no mem_wr_en, and busy=0 throughout.
4. Source stalls: byte_valid toggled 1/0 with random gaps, and start pulsed mid-load. Expect byte_ready low in WRITE, no byte lost or duplicated, correct data, and the mid-load start ignored.
5. Reset mid-word: assert reset after the high byte is accepted for word 2 of 3. Expect all outputs 0 at once, only word 1 written, and no done pulse. A subsequent full load succeeds.
6. Full memory: num_words=64 from base 0 with data equal to the index. Expect 64 writes covering addresses 0..63 once each, reads back matching, and done exactly once.
